// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state type and latency helper for the sequential ALU.
package alu_pkg;

   localparam int OP_ADD   = 1;
   localparam int OP_SUB   = 2;
   localparam int OP_MUL   = 3;
   localparam int OP_MOD   = 4;
   localparam int OP_PASSA = 5;
   localparam int OP_PASSB = 6;
   localparam int OP_INCA  = 7;
   localparam int OP_DECA  = 8;
   localparam int OP_CLR   = 9;
   localparam int OP_DIV   = 10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC1 = 2'd1,
      ST_ITER  = 2'd2,
      ST_FIN   = 2'd3
   } alu_state_t;

   // Cycles busy stays high after accept; a zero divisor short-circuits to one cycle.
   function automatic int op_latency(input int op, input logic b_zero, input int width);
      int lat;
      lat = 1;
      if (op == OP_MUL) lat = width + 1;
      else if ((op == OP_DIV || op == OP_MOD) && !b_zero) lat = width + 1;
      return lat;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle of the sequential ALU; the ALU sits on the slave modport.
interface alu_seq_if #(
   parameter int WIDTH = 32,
   parameter int CW    = 4
);
   import alu_pkg::*;

   // enable is the request and !busy the ready: an operation is accepted on the
   // rising edge where both hold; control/a_bus/b_bus are only sampled on that edge.
   logic             enable;
   logic [CW-1:0]    control;
   logic [WIDTH-1:0] a_bus;
   logic [WIDTH-1:0] b_bus;
   logic [WIDTH-1:0] c_bus;
   logic [WIDTH-1:0] c_hi;
   logic             z_flag;
   logic             dz_flag;
   logic             busy;
   logic             done;
   alu_state_t       state_dbg;

   modport master (
      output enable, control, a_bus, b_bus,
      input  c_bus, c_hi, z_flag, dz_flag, busy, done, state_dbg
   );

   modport slave (
      input  enable, control, a_bus, b_bus,
      output c_bus, c_hi, z_flag, dz_flag, busy, done, state_dbg
   );

endinterface

// File: rtl/alu_iter_unit.sv
// Bit-serial datapath: shift-add multiply and restoring divide, one bit per step.
module alu_iter_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             div_mode,
   input  logic             step,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] out_hi,
   output logic [WIDTH-1:0] out_lo
);

   // hi_q: partial product / remainder; lo_q: multiplier / dividend becoming quotient.
   logic [WIDTH-1:0] hi_q, lo_q, opd_q;
   logic             mode_q;
   logic [WIDTH:0]   sum, shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   always_comb begin
      sum     = {1'b0, hi_q} + {1'b0, opd_q};
      shifted = {hi_q, lo_q[WIDTH-1]};
      fits    = (shifted >= {1'b0, opd_q});
      diff    = shifted[WIDTH-1:0] - opd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q   <= '0;
         lo_q   <= '0;
         opd_q  <= '0;
         mode_q <= 1'b0;
      end else if (start) begin
         hi_q   <= '0;
         lo_q   <= div_mode ? op_a : op_b;
         opd_q  <= div_mode ? op_b : op_a;
         mode_q <= div_mode;
      end else if (step) begin
         if (mode_q) begin
            hi_q <= fits ? diff : shifted[WIDTH-1:0];
            lo_q <= {lo_q[WIDTH-2:0], fits};
         end else if (lo_q[0]) begin
            hi_q <= sum[WIDTH:1];
            lo_q <= {sum[0], lo_q[WIDTH-1:1]};
         end else begin
            hi_q <= {1'b0, hi_q[WIDTH-1:1]};
            lo_q <= {hi_q[0], lo_q[WIDTH-1:1]};
         end
      end
   end

   assign out_hi = hi_q;
   assign out_lo = lo_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU top: control FSM, single-cycle ops and registered results.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CW    = 4
) (
   input logic      clk,
   input logic      rst_n,
   alu_seq_if.slave bus
);

   localparam int CTRW = $clog2(WIDTH);

   alu_state_t       state, state_nxt;
   logic [CTRW-1:0]  ctr;
   logic [CW-1:0]    op_q;
   logic [WIDTH-1:0] a_q, b_q, c_bus_q, c_hi_q;
   logic             z_q, dz_q, busy_q, done_q;
   logic             accept, iter_op;
   logic [WIDTH-1:0] iter_hi, iter_lo, res_lo, res_hi;
   logic             wr_res, res_dz;

   assign accept  = bus.enable && !busy_q;
   assign iter_op = op_latency(int'(bus.control), (bus.b_bus == '0), WIDTH) > 1;

   alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept && iter_op),
      .div_mode (bus.control != CW'(OP_MUL)),
      .step     (state == ST_ITER),
      .op_a     (bus.a_bus),
      .op_b     (bus.b_bus),
      .out_hi   (iter_hi),
      .out_lo   (iter_lo)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = iter_op ? ST_ITER : ST_EXEC1;
         ST_ITER: if (ctr == '0) state_nxt = ST_FIN;
         default: state_nxt = accept ? (iter_op ? ST_ITER : ST_EXEC1) : ST_IDLE;
      endcase
   end

   // Result selection on the completion cycle; illegal opcodes write nothing but dz.
   always_comb begin
      wr_res = 1'b0;
      res_lo = '0;
      res_hi = '0;
      res_dz = 1'b0;
      if (state == ST_FIN) begin
         wr_res = 1'b1;
         if (op_q == CW'(OP_MUL)) begin
            res_hi = iter_hi;
            res_lo = iter_lo;
         end else if (op_q == CW'(OP_DIV)) res_lo = iter_lo;
         else res_lo = iter_hi;
      end else if (state == ST_EXEC1) begin
         wr_res = 1'b1;
         case (op_q)
            CW'(OP_ADD):   res_lo = a_q + b_q;
            CW'(OP_SUB):   res_lo = a_q - b_q;
            CW'(OP_PASSA): res_lo = a_q;
            CW'(OP_PASSB): res_lo = b_q;
            CW'(OP_INCA):  res_lo = a_q + WIDTH'(1);
            CW'(OP_DECA):  res_lo = a_q - WIDTH'(1);
            CW'(OP_CLR):   res_lo = '0;
            CW'(OP_DIV):   begin res_lo = '1; res_dz = 1'b1; end
            CW'(OP_MOD):   begin res_lo = '0; res_dz = 1'b1; end
            default:       wr_res = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr     <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_bus_q <= '0;
         c_hi_q  <= '0;
         z_q     <= 1'b1;
         dz_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            op_q   <= bus.control;
            a_q    <= bus.a_bus;
            b_q    <= bus.b_bus;
            busy_q <= 1'b1;
            ctr    <= iter_op ? CTRW'(WIDTH - 1) : '0;
         end else if (state == ST_ITER && ctr != '0) begin
            ctr <= ctr - CTRW'(1);
         end
         if (state == ST_EXEC1 || state == ST_FIN) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dz_q   <= res_dz;
            if (wr_res) begin
               c_bus_q <= res_lo;
               c_hi_q  <= res_hi;
               z_q     <= (res_lo == '0);
            end
         end
      end
   end

   assign bus.c_bus     = c_bus_q;
   assign bus.c_hi      = c_hi_q;
   assign bus.z_flag    = z_q;
   assign bus.dz_flag   = dz_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.state_dbg = state;

endmodule
